// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_if
//  Description : Signal bundle between the multicycle control FSM and the
//                datapath / memory side.
//                master : the controller (drives strobes, selects, status)
//                slave  : datapath/memories (drive opcode, format, acks,
//                         branch condition)
//  Signals     : opcode[6:0], format[2:0], imem_ack, dmem_ack, br_taken,
//                imem_req, ir_we, pc_we, dmem_re, dmem_we, rf_we,
//                pc_sel[1:0], wb_sel[1:0], state[2:0], trap,
//                trap_cause[1:0], instret[31:0]
//  Revision    : 1.0  initial release
// ============================================================================
interface multicycle_ctrl_if;
    logic [6:0]  opcode;
    logic [2:0]  format;
    logic        imem_ack;
    logic        dmem_ack;
    logic        br_taken;

    logic        imem_req;
    logic        ir_we;
    logic        pc_we;
    logic        dmem_re;
    logic        dmem_we;
    logic        rf_we;
    logic [1:0]  pc_sel;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] instret;

    modport master (
        input  opcode, format, imem_ack, dmem_ack, br_taken,
        output imem_req, ir_we, pc_we, dmem_re, dmem_we, rf_we,
        output pc_sel, wb_sel, state, trap, trap_cause, instret
    );

    modport slave (
        output opcode, format, imem_ack, dmem_ack, br_taken,
        input  imem_req, ir_we, pc_we, dmem_re, dmem_we, rf_we,
        input  pc_sel, wb_sel, state, trap, trap_cause, instret
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Control FSM of a multicycle RISC-V style core.
//                IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH,
//                with a sticky TRAP state for illegal formats and memory
//                ack timeouts. Strobes are decoded combinationally from the
//                state, the latched opcode and the ack inputs.
//  Parameters  : WAIT_MAX - max cycles a memory request waits for ack (2..15)
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - multicycle_ctrl_if.master (inputs: opcode, format,
//                         imem_ack, dmem_ack, br_taken; outputs: strobes,
//                         pc_sel, wb_sel, state, trap, trap_cause, instret)
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int WAIT_MAX = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    multicycle_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] c_OP_LOAD   = 7'd3;
    localparam logic [6:0] c_OP_STORE  = 7'd35;
    localparam logic [6:0] c_OP_BRANCH = 7'd99;
    localparam logic [6:0] c_OP_JAL    = 7'd111;
    localparam logic [6:0] c_OP_JALR   = 7'd103;

    localparam logic [2:0] c_FMT_UNDEF = 3'd7;

    localparam logic [1:0] c_CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] c_CAUSE_IMEM_TO = 2'd2;
    localparam logic [1:0] c_CAUSE_DMEM_TO = 2'd3;

    // Last wait-counter value at which an ack is still accepted.
    localparam logic [3:0] c_WAIT_LAST = 4'(WAIT_MAX - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [6:0]  r_opc_q;
    logic [3:0]  r_wait_cnt;
    logic [1:0]  r_trap_cause;
    logic [1:0]  w_cause_nxt;
    logic [31:0] r_instret;

    logic        w_imem_req;
    logic        w_ir_we;
    logic        w_pc_we;
    logic        w_dmem_re;
    logic        w_dmem_we;
    logic        w_rf_we;
    logic [1:0]  w_pc_sel;
    logic [1:0]  w_wb_sel;
    logic        w_wait_limit;
    logic        w_waiting;

    assign w_wait_limit = (r_wait_cnt == c_WAIT_LAST);
    assign w_waiting    = (r_state == S_FETCH) || (r_state == S_MEM);

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_trap_cause;
        w_imem_req  = 1'b0;
        w_ir_we     = 1'b0;
        w_pc_we     = 1'b0;
        w_dmem_re   = 1'b0;
        w_dmem_we   = 1'b0;
        w_rf_we     = 1'b0;
        w_pc_sel    = 2'd0;
        w_wb_sel    = 2'd0;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end

            S_FETCH: begin
                w_imem_req = 1'b1;
                // An ack on the limit cycle takes priority over the timeout.
                if (bus.imem_ack) begin
                    w_ir_we     = 1'b1;
                    w_state_nxt = S_DECODE;
                end else if (w_wait_limit) begin
                    w_state_nxt = S_TRAP;
                    w_cause_nxt = c_CAUSE_IMEM_TO;
                end
            end

            S_DECODE: begin
                if (bus.format == c_FMT_UNDEF) begin
                    w_state_nxt = S_TRAP;
                    w_cause_nxt = c_CAUSE_ILLEGAL;
                end else begin
                    w_state_nxt = S_EXEC;
                end
            end

            S_EXEC: begin
                if ((r_opc_q == c_OP_LOAD) || (r_opc_q == c_OP_STORE)) begin
                    w_state_nxt = S_MEM;
                end else if (r_opc_q == c_OP_BRANCH) begin
                    w_pc_we     = 1'b1;
                    w_pc_sel    = bus.br_taken ? 2'd1 : 2'd0;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_WB;
                end
            end

            S_MEM: begin
                w_dmem_re = (r_opc_q == c_OP_LOAD);
                w_dmem_we = (r_opc_q == c_OP_STORE);
                if (bus.dmem_ack) begin
                    if (r_opc_q == c_OP_STORE) begin
                        // Stores retire here; there is nothing to write back.
                        w_pc_we     = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end else if (w_wait_limit) begin
                    w_state_nxt = S_TRAP;
                    w_cause_nxt = c_CAUSE_DMEM_TO;
                end
            end

            S_WB: begin
                w_pc_we     = 1'b1;
                w_rf_we     = (r_opc_q != c_OP_STORE) && (r_opc_q != c_OP_BRANCH);
                w_state_nxt = S_FETCH;
                case (r_opc_q)
                    c_OP_LOAD: w_wb_sel = 2'd1;
                    c_OP_JAL:  w_wb_sel = 2'd2;
                    c_OP_JALR: w_wb_sel = 2'd2;
                    default:   w_wb_sel = 2'd0;
                endcase
                case (r_opc_q)
                    c_OP_JAL:  w_pc_sel = 2'd1;
                    c_OP_JALR: w_pc_sel = 2'd2;
                    default:   w_pc_sel = 2'd0;
                endcase
            end

            S_TRAP: begin
                w_state_nxt = S_TRAP;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, latched opcode, wait counter, trap cause, retired count
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_opc_q      <= 7'd0;
            r_wait_cnt   <= 4'd0;
            r_trap_cause <= 2'd0;
            r_instret    <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_trap_cause <= w_cause_nxt;
            if (r_state == S_DECODE) begin
                r_opc_q <= bus.opcode;
            end
            // Counts only while parked in a waiting state; any transition
            // (including entry into FETCH/MEM) restarts it from zero.
            if (w_waiting && (w_state_nxt == r_state)) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end else begin
                r_wait_cnt <= 4'd0;
            end
            r_instret <= r_instret + {31'd0, w_pc_we};
        end
    end

    assign bus.imem_req   = w_imem_req;
    assign bus.ir_we      = w_ir_we;
    assign bus.pc_we      = w_pc_we;
    assign bus.dmem_re    = w_dmem_re;
    assign bus.dmem_we    = w_dmem_we;
    assign bus.rf_we      = w_rf_we;
    assign bus.pc_sel     = w_pc_sel;
    assign bus.wb_sel     = w_wb_sel;
    assign bus.state      = r_state;
    assign bus.trap       = (r_state == S_TRAP);
    assign bus.trap_cause = r_trap_cause;
    assign bus.instret    = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Directed self-checking bench for multicycle_ctrl.
//                Inputs are driven just after the falling edge; outputs are
//                sampled 1 ns later, well away from the rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.WAIT_MAX(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next falling edge.
    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    // Called in a FETCH cycle: ack the fetch, pass DECODE, end in EXEC.
    task automatic fetch_decode(input logic [6:0] op, input logic [2:0] fmt);
        chk("fd.fetch_state", 32'(bus.state), 1);
        bus.opcode   = op;
        bus.format   = fmt;
        bus.imem_ack = 1'b1;
        #1;
        chk("fd.ir_we", 32'(bus.ir_we), 1);
        nxt();
        bus.imem_ack = 1'b0;
        #1;
        chk("fd.decode_state", 32'(bus.state), 2);
        nxt();
        // Opcode is scrambled after DECODE: only the latched copy may matter.
        bus.opcode = 7'd0;
        bus.format = 3'd0;
        #1;
    endtask

    // Reset pulse; ends in the first FETCH cycle afterwards.
    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("rst.state", 32'(bus.state), 0);
        chk("rst.trap", 32'(bus.trap), 0);
        chk("rst.cause", 32'(bus.trap_cause), 0);
        chk("rst.instret", bus.instret, 0);
        nxt();
        rst_n = 1'b1;
        #1;
        chk("rst.idle", 32'(bus.state), 0);
        nxt();
    endtask

    initial begin
        bus.opcode   = 7'd0;
        bus.format   = 3'd0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.br_taken = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) nxt();
        chk("reset.state", 32'(bus.state), 0);
        chk("reset.strobes", {26'd0, bus.imem_req, bus.ir_we, bus.pc_we,
                              bus.dmem_re, bus.dmem_we, bus.rf_we}, 0);
        chk("reset.trap", 32'(bus.trap), 0);
        chk("reset.instret", bus.instret, 0);
        rst_n = 1'b1;
        #1;
        chk("release.idle", 32'(bus.state), 0);
        nxt();

        // ---------------- ADDI, ack on 2nd FETCH cycle ----------------
        chk("addi.f1_state", 32'(bus.state), 1);
        chk("addi.f1_req", 32'(bus.imem_req), 1);
        chk("addi.f1_ir_we", 32'(bus.ir_we), 0);
        bus.dmem_ack = 1'b1;  // stray ack, must be ignored
        #1;
        chk("addi.stray_dmem_re", 32'(bus.dmem_re), 0);
        nxt();
        bus.dmem_ack = 1'b0;
        fetch_decode(7'd19, 3'd1);
        chk("addi.exec_state", 32'(bus.state), 3);
        chk("addi.exec_pc_we", 32'(bus.pc_we), 0);
        chk("addi.exec_rf_we", 32'(bus.rf_we), 0);
        nxt();
        chk("addi.wb_state", 32'(bus.state), 5);
        chk("addi.wb_rf_we", 32'(bus.rf_we), 1);
        chk("addi.wb_sel", 32'(bus.wb_sel), 0);
        chk("addi.wb_pc_we", 32'(bus.pc_we), 1);
        chk("addi.wb_pc_sel", 32'(bus.pc_sel), 0);
        nxt();
        chk("addi.back_fetch", 32'(bus.state), 1);
        chk("addi.instret", bus.instret, 1);

        // ---------------- load, ack on 3rd MEM cycle ----------------
        fetch_decode(7'd3, 3'd1);
        nxt();
        for (int i = 0; i < 2; i++) begin
            chk("ld.mem_state", 32'(bus.state), 4);
            chk("ld.dmem_re", 32'(bus.dmem_re), 1);
            chk("ld.dmem_we", 32'(bus.dmem_we), 0);
            nxt();
        end
        bus.dmem_ack = 1'b1;
        #1;
        chk("ld.dmem_re_c3", 32'(bus.dmem_re), 1);
        chk("ld.pc_we_c3", 32'(bus.pc_we), 0);
        nxt();
        bus.dmem_ack = 1'b0;
        #1;
        chk("ld.wb_state", 32'(bus.state), 5);
        chk("ld.wb_sel", 32'(bus.wb_sel), 1);
        chk("ld.rf_we", 32'(bus.rf_we), 1);
        chk("ld.dmem_re_wb", 32'(bus.dmem_re), 0);
        nxt();
        chk("ld.instret", bus.instret, 2);

        // ---------------- store ----------------
        fetch_decode(7'd35, 3'd2);
        nxt();
        chk("st.dmem_we", 32'(bus.dmem_we), 1);
        chk("st.dmem_re", 32'(bus.dmem_re), 0);
        chk("st.rf_we_wait", 32'(bus.rf_we), 0);
        chk("st.pc_we_wait", 32'(bus.pc_we), 0);
        bus.dmem_ack = 1'b1;
        #1;
        chk("st.pc_we", 32'(bus.pc_we), 1);
        chk("st.pc_sel", 32'(bus.pc_sel), 0);
        chk("st.rf_we", 32'(bus.rf_we), 0);
        nxt();
        bus.dmem_ack = 1'b0;
        chk("st.back_fetch", 32'(bus.state), 1);
        chk("st.instret", bus.instret, 3);

        // ---------------- branch taken / not taken ----------------
        fetch_decode(7'd99, 3'd3);
        bus.br_taken = 1'b1;
        #1;
        chk("bt.pc_we", 32'(bus.pc_we), 1);
        chk("bt.pc_sel", 32'(bus.pc_sel), 1);
        chk("bt.rf_we", 32'(bus.rf_we), 0);
        nxt();
        bus.br_taken = 1'b0;
        chk("bt.back_fetch", 32'(bus.state), 1);
        fetch_decode(7'd99, 3'd3);
        chk("bn.pc_we", 32'(bus.pc_we), 1);
        chk("bn.pc_sel", 32'(bus.pc_sel), 0);
        nxt();
        chk("bn.back_fetch", 32'(bus.state), 1);
        chk("bn.instret", bus.instret, 5);

        // ---------------- JALR and JAL ----------------
        fetch_decode(7'd103, 3'd1);
        nxt();
        chk("jalr.state", 32'(bus.state), 5);
        chk("jalr.pc_sel", 32'(bus.pc_sel), 2);
        chk("jalr.wb_sel", 32'(bus.wb_sel), 2);
        chk("jalr.rf_we", 32'(bus.rf_we), 1);
        nxt();
        fetch_decode(7'd111, 3'd5);
        nxt();
        chk("jal.pc_sel", 32'(bus.pc_sel), 1);
        chk("jal.wb_sel", 32'(bus.wb_sel), 2);
        nxt();
        chk("jal.instret", bus.instret, 7);

        // ---------------- instret wrap ----------------
        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        #1;
        chk("wrap.preload", bus.instret, 32'hFFFF_FFFF);
        fetch_decode(7'd51, 3'd0);
        nxt();
        chk("wrap.wb_sel", 32'(bus.wb_sel), 0);
        chk("wrap.pc_we", 32'(bus.pc_we), 1);
        nxt();
        chk("wrap.instret", bus.instret, 0);

        // ---------------- MEM timeout ----------------
        fetch_decode(7'd3, 3'd1);
        nxt();
        for (int i = 0; i < 8; i++) begin
            chk("memto.waiting", 32'(bus.state), 4);
            nxt();
        end
        chk("memto.state", 32'(bus.state), 6);
        chk("memto.trap", 32'(bus.trap), 1);
        chk("memto.cause", 32'(bus.trap_cause), 3);
        chk("memto.dmem_re", 32'(bus.dmem_re), 0);
        reset_pulse();

        // ---------------- FETCH timeout ----------------
        for (int i = 0; i < 8; i++) begin
            chk("ifto.waiting", 32'(bus.state), 1);
            nxt();
        end
        chk("ifto.state", 32'(bus.state), 6);
        chk("ifto.cause", 32'(bus.trap_cause), 2);
        chk("ifto.imem_req", 32'(bus.imem_req), 0);
        bus.imem_ack = 1'b1;
        #1;
        chk("ifto.ir_we_ignored", 32'(bus.ir_we), 0);
        repeat (2) nxt();
        bus.imem_ack = 1'b0;
        chk("ifto.sticky", 32'(bus.state), 6);
        chk("ifto.cause_held", 32'(bus.trap_cause), 2);
        reset_pulse();

        // ---------------- ack on the limit cycle wins ----------------
        repeat (7) nxt();
        fetch_decode(7'd19, 3'd1);
        chk("limit.exec", 32'(bus.state), 3);
        chk("limit.no_trap", 32'(bus.trap), 0);
        repeat (2) nxt();

        // ---------------- illegal format ----------------
        fetch_decode(7'd0, 3'd7);
        chk("undef.state", 32'(bus.state), 6);
        chk("undef.cause", 32'(bus.trap_cause), 1);
        chk("undef.trap", 32'(bus.trap), 1);
        bus.imem_ack = 1'b1;
        repeat (3) nxt();
        chk("undef.sticky", 32'(bus.state), 6);
        chk("undef.ir_we", 32'(bus.ir_we), 0);
        chk("undef.imem_req", 32'(bus.imem_req), 0);
        bus.imem_ack = 1'b0;
        reset_pulse();

        // ---------------- reset during MEM (load, then store) ----------------
        fetch_decode(7'd3, 3'd1);
        nxt();
        chk("abort_ld.dmem_re", 32'(bus.dmem_re), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_ld.dmem_re0", 32'(bus.dmem_re), 0);
        chk("abort_ld.state", 32'(bus.state), 0);
        nxt();
        rst_n = 1'b1;
        nxt();
        fetch_decode(7'd35, 3'd2);
        nxt();
        chk("abort_st.dmem_we", 32'(bus.dmem_we), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_st.dmem_we0", 32'(bus.dmem_we), 0);
        chk("abort_st.state", 32'(bus.state), 0);
        nxt();
        rst_n = 1'b1;
        nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
